// File: rtl/boss_missile_control.sv
// Boss missile manager: three falling missile slots, fire cadence, hit detection, player lives.
// Latency: slot/lives state updates on the Clk edge that sees a frame_clk rising edge; is_boss_missile is combinational.
// Backpressure: none; when all slots are busy the expired fire counter holds at zero until a slot frees up.
module boss_missile_control #(
    parameter int FIRE_PERIOD   = 60,
    parameter int MISSILE_SPEED = 4,
    parameter int HIT_THRESHOLD = 16,
    parameter int START_LIVES   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] boss_x_pos,
    input  logic [9:0] boss_y_pos,
    input  logic [9:0] player_x_pos,
    input  logic [9:0] player_y_pos,
    output logic       is_boss_missile,
    output logic [1:0] lives,
    output logic       is_player_dead
);

    localparam int                 NSLOT     = 3;
    localparam int                 CW        = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [CW-1:0]      RELOAD    = CW'(FIRE_PERIOD - 1);
    localparam logic [10:0]        SPEED11   = 11'(MISSILE_SPEED);
    localparam logic [9:0]         SPEED10   = 10'(MISSILE_SPEED);
    localparam logic signed [10:0] THR       = 11'(HIT_THRESHOLD);
    localparam logic [10:0]        Y_MAX     = 11'd479;
    localparam logic [9:0]         LAUNCH_DY = 10'd24;

    logic              frame_clk_q, frame_clk_d;
    logic              tick;
    logic [NSLOT-1:0]  active_q, active_d;
    logic [9:0]        x_q [NSLOT];
    logic [9:0]        x_d [NSLOT];
    logic [9:0]        y_q [NSLOT];
    logic [9:0]        y_d [NSLOT];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        lives_q, lives_d;
    logic              dead_q, dead_d;

    logic signed [10:0] dx [NSLOT];
    logic signed [10:0] dy [NSLOT];
    logic signed [10:0] adx [NSLOT];
    logic signed [10:0] ady [NSLOT];
    logic [NSLOT-1:0]   hit;
    logic               launched;

    assign tick           = frame_clk & ~frame_clk_q;
    assign frame_clk_d    = frame_clk;
    assign lives          = lives_q;
    assign is_player_dead = dead_q;

    // Per-slot hit test on the current (pre-move) position, signed 11-bit so distances never wrap
    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLOT; i++) begin
            dx[i]  = $signed({1'b0, x_q[i]}) - $signed({1'b0, player_x_pos});
            dy[i]  = $signed({1'b0, y_q[i]}) - $signed({1'b0, player_y_pos});
            adx[i] = dx[i][10] ? -dx[i] : dx[i];
            ady[i] = dy[i][10] ? -dy[i] : dy[i];
            hit[i] = active_q[i] && (adx[i] < THR) && (ady[i] < THR);
        end
    end

    // Frame-tick update: hits beat moves, freed slots wait a tick, one life lost per tick at most
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        lives_d  = lives_q;
        dead_d   = dead_q;
        launched = 1'b0;
        if (tick && enable && !dead_q) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (active_q[i]) begin
                    if (hit[i]) begin
                        active_d[i] = 1'b0;
                    end else if (({1'b0, y_q[i]} + SPEED11) > Y_MAX) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] + SPEED10;
                    end
                end
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (active_q != '1) begin
                // Only slots free at the start of the tick may launch
                for (int i = 0; i < NSLOT; i++) begin
                    if (!active_q[i] && !launched) begin
                        launched    = 1'b1;
                        active_d[i] = 1'b1;
                        x_d[i]      = boss_x_pos;
                        y_d[i]      = boss_y_pos + LAUNCH_DY;
                    end
                end
                cnt_d = RELOAD;
            end
            if (hit != '0) begin
                if (lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
                if (lives_q <= 2'd1) begin
                    dead_d   = 1'b1;
                    active_d = '0;
                    for (int i = 0; i < NSLOT; i++) begin
                        x_d[i] = '0;
                        y_d[i] = '0;
                    end
                end
            end
        end
    end

    // Pixel hit-box x-2..x+1, y-4..y+3 rewritten as additions at 11 bits to avoid edge wrap
    always_comb begin
        is_boss_missile = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (active_q[i]
                && ({1'b0, x_q[i]} <= ({1'b0, DrawX} + 11'd2))
                && ({1'b0, DrawX} <= ({1'b0, x_q[i]} + 11'd1))
                && ({1'b0, y_q[i]} <= ({1'b0, DrawY} + 11'd4))
                && ({1'b0, DrawY} <= ({1'b0, y_q[i]} + 11'd3))) begin
                is_boss_missile = 1'b1;
            end
        end
        if (Reset) begin
            is_boss_missile = 1'b0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            active_q    <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            cnt_q       <= RELOAD;
            lives_q     <= 2'(START_LIVES);
            dead_q      <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk_d;
            active_q    <= active_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            dead_q      <= dead_d;
        end
    end

endmodule

// File: tb/tb_boss_missile_control.sv
// Bench for boss_missile_control: randomized and targeted stimulus vs. a slot-list reference model.
// Expected outputs are queued at probe time and compared by an independent monitor.
// Fire period shortened to 20 ticks so slot-full and reuse situations occur quickly.
module tb_boss_missile_control;

    localparam int P = 20;
    localparam int S = 4;
    localparam int T = 16;
    localparam int L = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [9:0] DrawX, DrawY;
    logic [9:0] boss_x_pos, boss_y_pos, player_x_pos, player_y_pos;
    logic       is_boss_missile;
    logic [1:0] lives;
    logic       is_player_dead;

    always #5 Clk = ~Clk;

    boss_missile_control #(
        .FIRE_PERIOD(P), .MISSILE_SPEED(S), .HIT_THRESHOLD(T), .START_LIVES(L)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
        .DrawX(DrawX), .DrawY(DrawY),
        .boss_x_pos(boss_x_pos), .boss_y_pos(boss_y_pos),
        .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
        .is_boss_missile(is_boss_missile), .lives(lives), .is_player_dead(is_player_dead)
    );

    // ---------------- reference model ----------------
    int m_act [3];
    int m_x   [3];
    int m_y   [3];
    int m_cnt, m_lives, m_dead;

    typedef struct {
        int dx; int dy; int pix; int lv; int dd;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    function automatic int absv(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int m_pix(input int px, input int py);
        for (int i = 0; i < 3; i++)
            if (m_act[i] != 0 && px >= m_x[i] - 2 && px <= m_x[i] + 1 &&
                py >= m_y[i] - 4 && py <= m_y[i] + 3)
                return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_cnt = P - 1; m_lives = L; m_dead = 0;
    endtask

    task automatic model_tick();
        int was [3];
        int hits, bx, by, px, py, slot;
        if (m_dead != 0 || enable == 1'b0) return;
        bx = int'(boss_x_pos); by = int'(boss_y_pos);
        px = int'(player_x_pos); py = int'(player_y_pos);
        hits = 0;
        for (int i = 0; i < 3; i++) was[i] = m_act[i];
        for (int i = 0; i < 3; i++) begin
            if (was[i] != 0) begin
                if (absv(m_x[i] - px) < T && absv(m_y[i] - py) < T) begin
                    m_act[i] = 0; hits++;
                end else if (m_y[i] + S > 479) begin
                    m_act[i] = 0;
                end else begin
                    m_y[i] = m_y[i] + S;
                end
            end
        end
        if (m_cnt > 0) begin
            m_cnt--;
        end else begin
            slot = -1;
            for (int i = 2; i >= 0; i--) if (was[i] == 0) slot = i;
            if (slot >= 0) begin
                m_act[slot] = 1; m_x[slot] = bx; m_y[slot] = (by + 24) % 1024;
                m_cnt = P - 1;
            end
        end
        if (hits > 0 && m_lives > 0) begin
            m_lives--;
            if (m_lives == 0) begin
                m_dead = 1;
                for (int i = 0; i < 3; i++) m_act[i] = 0;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int bx, input int by, input int px, input int py);
        boss_x_pos = 10'(bx); boss_y_pos = 10'(by);
        player_x_pos = 10'(px); player_y_pos = 10'(py);
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        @(posedge Clk); #1;
        model_tick();
        @(posedge Clk); #1;
        frame_clk = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic push_hold(input int dx, input int dy, input int pix, input int lv, input int dd);
        exp_t e;
        DrawX = 10'(dx); DrawY = 10'(dy);
        e.dx = dx; e.dy = dy; e.pix = pix; e.lv = lv; e.dd = dd;
        q.push_back(e);
        @(posedge Clk); #1;
    endtask

    task automatic probe(input int dx, input int dy);
        push_hold(dx, dy, m_pix(dx, dy), m_lives, m_dead);
    endtask

    task automatic dcheck(input int dx, input int dy, input int pix, input int lv, input int dd);
        push_hold(dx, dy, pix, lv, dd);
    endtask

    task automatic rand_probes();
        for (int i = 0; i < 3; i++)
            probe((m_x[i] + int'($urandom_range(0, 5)) - 3) & 1023,
                  (m_y[i] + int'($urandom_range(0, 9)) - 5) & 1023);
        probe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    endtask

    task automatic pulse_reset();
        int sx, sy;
        sx = 0; sy = 0;
        for (int i = 2; i >= 0; i--) if (m_act[i] != 0) begin sx = m_x[i]; sy = m_y[i]; end
        Reset = 1'b1; frame_clk = 1'b0;
        model_reset();
        dcheck(sx, sy, 0, L, 0);
        dcheck(sx + 1, sy + 3, 0, L, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        dcheck(sx, sy, 0, L, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(is_boss_missile) != e.pix) begin
                    errors++;
                    $display("FAIL pixel(%0d,%0d): got %0d expected %0d at %0t", e.dx, e.dy, is_boss_missile, e.pix, $time);
                end
                checks++;
                if (int'(lives) != e.lv) begin
                    errors++;
                    $display("FAIL lives: got %0d expected %0d at %0t", lives, e.lv, $time);
                end
                checks++;
                if (int'(is_player_dead) != e.dd) begin
                    errors++;
                    $display("FAIL dead_flag: got %0d expected %0d at %0t", is_player_dead, e.dd, $time);
                end
            end
        end
    end

    // Watchdog: the sequence below is finite, this only guards against a stuck simulator
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int bound;
        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0;
        DrawX = '0; DrawY = '0;
        set_in(320, 100, 600, 20);
        model_reset();
        repeat (2) @(posedge Clk); #1;
        dcheck(0, 0, 0, 3, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        dcheck(320, 124, 0, 3, 0);

        // Cadence, off-screen reuse, slots full
        enable = 1'b1;
        for (int t = 1; t <= 129; t++) begin
            do_tick();
            rand_probes();
            case (t)
                19:  dcheck(320, 124, 0, 3, 0);
                20:  begin dcheck(320, 124, 1, 3, 0); dcheck(320, 127, 1, 3, 0); dcheck(320, 128, 0, 3, 0); end
                21:  begin dcheck(320, 128, 1, 3, 0); dcheck(320, 131, 1, 3, 0); dcheck(320, 132, 0, 3, 0); end
                40:  dcheck(320, 124, 1, 3, 0);
                80:  dcheck(320, 124, 0, 3, 0);
                100: dcheck(320, 124, 0, 3, 0);
                108: dcheck(320, 476, 1, 3, 0);
                109: begin dcheck(320, 476, 0, 3, 0); dcheck(320, 124, 0, 3, 0); end
                110: dcheck(320, 124, 1, 3, 0);
                default: ;
            endcase
        end

        // Pixel box and freeze around a missile at (100,200)
        set_in(100, 176, 600, 20);
        do_tick();
        rand_probes();
        dcheck(98, 196, 1, 3, 0); dcheck(101, 203, 1, 3, 0); dcheck(102, 200, 0, 3, 0);
        dcheck(97, 200, 0, 3, 0); dcheck(100, 195, 0, 3, 0); dcheck(100, 204, 0, 3, 0);
        enable = 1'b0;
        for (int t = 0; t < 10; t++) begin do_tick(); rand_probes(); end
        dcheck(98, 196, 1, 3, 0); dcheck(101, 203, 1, 3, 0); dcheck(102, 200, 0, 3, 0);
        enable = 1'b1;

        // Multi-hit: two missiles on the player on one tick cost one life
        pulse_reset();
        set_in(200, 100, 600, 20);
        for (int t = 1; t <= 41; t++) begin
            if (t == 40) set_in(200, 180, 600, 20);
            if (t == 41) set_in(200, 100, 200, 204);
            do_tick();
            rand_probes();
        end
        dcheck(200, 204, 0, 2, 0);
        dcheck(200, 208, 0, 2, 0);

        // Death: keep the player in the missile path until lives run out
        set_in(200, 100, 200, 300);
        bound = 0;
        while (m_dead == 0 && bound < 200) begin
            do_tick();
            rand_probes();
            bound++;
        end
        if (m_dead == 0) begin
            checks++; errors++;
            $display("FAIL death_wait: model still alive after %0d ticks", bound);
        end
        dcheck(200, 300, 0, 0, 1);
        for (int t = 1; t <= 30; t++) begin
            do_tick();
            rand_probes();
            if (t % 10 == 0) dcheck(200, 124, 0, 0, 1);
        end
        pulse_reset();
        dcheck(200, 124, 0, 3, 0);

        // Randomized rounds
        for (int r = 0; r < 3; r++) begin
            pulse_reset();
            for (int t = 0; t < 250; t++) begin
                int k, px, py;
                if ($urandom_range(0, 3) == 0)
                    set_in(int'($urandom_range(0, 639)), int'($urandom_range(0, 470)),
                           int'(player_x_pos), int'(player_y_pos));
                k = int'($urandom_range(0, 2));
                if (m_act[k] != 0 && $urandom_range(0, 1) == 0) begin
                    px = (m_x[k] + int'($urandom_range(0, 40)) - 20) & 1023;
                    py = (m_y[k] + int'($urandom_range(0, 40)) - 20) & 1023;
                end else begin
                    px = int'($urandom_range(0, 639));
                    py = int'($urandom_range(0, 479));
                end
                player_x_pos = 10'(px); player_y_pos = 10'(py);
                enable = ($urandom_range(0, 9) != 0);
                do_tick();
                rand_probes();
            end
        end

        // Drain the scoreboard
        bound = 0;
        while (q.size() > 0 && bound < 10) begin
            @(posedge Clk); #1;
            bound++;
        end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boss_missile_control.md
BOSS_MISSILE_CONTROL -- requirements
Module: boss_missile_control

Interface
REQ-001 SHALL provide parameter FIRE_PERIOD, default 60, frame ticks between boss shots.
REQ-002 SHALL provide parameter MISSILE_SPEED, default 4, pixels of downward motion per frame tick.
REQ-003 SHALL provide parameter HIT_THRESHOLD, default 16, per-axis hit distance in pixels.
REQ-004 SHALL provide parameter START_LIVES, default 3, player lives after reset (range 1..3).
REQ-005 SHALL provide ports, in this order:
  Clk  in  1  system clock, single clock domain;
  Reset  in  1  asynchronous, active-high reset;
  frame_clk  in  1  VGA frame strobe, synchronous to Clk;
  enable  in  1  1 = level running, 0 = freeze;
  DrawX, DrawY  in  10  current pixel coordinate;
  boss_x_pos, boss_y_pos  in  10  boss centre;
  player_x_pos, player_y_pos  in  10  player centre;
  is_boss_missile  out  1  current pixel lies on an active boss missile;
  lives  out  2  remaining player lives;
  is_player_dead  out  1  sticky loss flag, drives the level's is_lost.

Function
REQ-006 SHALL register frame_clk each Clk cycle and SHALL generate a one-cycle frame tick when frame_clk = 1 and its registered value = 0.
REQ-007 SHALL hold 3 missile slots, each with an active bit and 10-bit x/y centre registers; every state update SHALL occur only on a frame-tick cycle.
REQ-008 SHALL keep a fire counter that decrements by 1 on each frame tick while enable = 1 and the counter is nonzero.
REQ-009 SHALL, on a tick where the counter = 0 and a slot is free, launch the lowest-index free slot at x = boss_x_pos, y = boss_y_pos + 24, and reload the counter with FIRE_PERIOD-1.
REQ-010 SHALL, when the counter = 0 and no slot is free, hold the counter at 0 and fire on the first tick on which a slot is free.
REQ-011 SHALL, on each tick, add MISSILE_SPEED to the y of every active slot that was not launched on that tick.
REQ-012 SHALL deactivate a slot when y + MISSILE_SPEED > 479, using 11-bit arithmetic; no wrap-around is permitted.
REQ-013 SHALL declare a hit for an active slot when |x - player_x_pos| < HIT_THRESHOLD and |y - player_y_pos| < HIT_THRESHOLD, evaluated on the pre-move position in 11-bit signed arithmetic.
REQ-014 SHALL deactivate every hitting slot and SHALL decrement lives by exactly 1 per tick, regardless of how many slots hit simultaneously.
REQ-015 SHALL give a hit priority over move and off-screen deactivation on the same tick.
REQ-016 SHALL free a slot on hit or off-screen and make it launchable on the next tick, not the same one.
REQ-017 SHALL, when lives reaches 0, set is_player_dead = 1 on the same tick, clear all slots, and stop firing and movement until Reset.
REQ-018 SHALL, while enable = 0, freeze the counter and all slots; hits SHALL NOT be evaluated.
REQ-019 SHALL drive is_boss_missile combinationally = 1 when any active slot satisfies x-2 <= DrawX <= x+1 and y-4 <= DrawY <= y+3, compared at 11 bits so the box does not wrap at the screen edges.
REQ-020 SHALL never decrement lives below 0.

Reset
REQ-021 SHALL, on Reset = 1 (asynchronous), clear all active bits and x/y registers to 0, set the fire counter to FIRE_PERIOD-1, lives to START_LIVES, is_player_dead to 0, and the frame_clk history register to 0.
REQ-022 SHALL, while Reset = 1, hold is_boss_missile = 0; reset asserted mid-flight SHALL remove all missiles immediately.

Verification
REQ-023 Fire cadence: boss (320,100), player far away, FIRE_PERIOD=60 -> slot0 launches at (320,124) on tick 60 after reset, slot1 on tick 120; y of slot0 at tick 61 = 128.
REQ-024 Off-screen: lone missile at y=476, speed 4 -> deactivates on the next tick; slot0 is reused on the following launch.
REQ-025 Slots full: keep all 3 slots active past a counter expiry -> no launch, counter stays 0; free one slot -> launch on the next tick.
REQ-026 Multi-hit: two missiles within threshold of the player on the same tick -> both cleared, lives 3 -> 2.
REQ-027 Death: three separate hits -> lives 0, is_player_dead = 1 on the third-hit tick, no further launches; pulse Reset -> lives 3, flag 0.
REQ-028 Pixel/freeze: missile at (100,200) -> is_boss_missile = 1 at DrawX/DrawY (98,196) and (101,203), 0 at (102,200); with enable = 0 for 10 ticks, position unchanged.
